// File: rtl/bulls_cows_game_ctrl_pkg.sv
// Shared types and constants for the Bulls and Cows game controller and its display stage.
package bulls_cows_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned CODE_W     = DIGIT_W * NUM_DIGITS;
  localparam int unsigned COUNT_W    = 3;
  localparam int unsigned POINTS_W   = 8;
  localparam int unsigned WIN_BULLS  = 4;
  localparam int unsigned POINTS_MAX = 255;

  // Encoding consumed by the seven-segment/LED display stage.
  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } game_state_t;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef digit_t [NUM_DIGITS-1:0] code_t;

  typedef enum logic [3:0] {
    S_J1_SETUP,
    S_J2_SETUP,
    S_J1_GUESS,
    S_J1_SCORE,
    S_J1_SHOW,
    S_J2_GUESS,
    S_J2_SCORE,
    S_J2_SHOW,
    S_END
  } ctrl_state_t;

endpackage

// File: rtl/bulls_cows_game_ctrl_if.sv
// Switch/confirm inputs and display-facing outputs of the game controller.
interface bulls_cows_game_ctrl_if;
  import bulls_cows_pkg::*;

  logic                confirm;
  logic [CODE_W-1:0]   SW;
  game_state_t         game_state;
  logic                guess_confirmed;
  logic [COUNT_W-1:0]  bull_count;
  logic [COUNT_W-1:0]  cow_count;
  logic [POINTS_W-1:0] J1_points;
  logic [POINTS_W-1:0] J2_points;
  logic                invalid_entry;

  modport master (
    output confirm, SW,
    input  game_state, guess_confirmed, bull_count, cow_count,
           J1_points, J2_points, invalid_entry
  );

  modport slave (
    input  confirm, SW,
    output game_state, guess_confirmed, bull_count, cow_count,
           J1_points, J2_points, invalid_entry
  );
endinterface

// File: rtl/bulls_cows_game_ctrl_scorer.sv
// Combinational guess scoring and entry validation (distinct digits).
// DECIMAL_DIGITS_EN additionally restricts every digit to 0..9.
module bulls_cows_scorer
  import bulls_cows_pkg::*;
(
  input  code_t              guess,
  input  code_t              secret,
  output logic [COUNT_W-1:0] bulls,
  output logic [COUNT_W-1:0] cows,
  output logic               entry_valid
);

  always_comb begin
    bulls       = '0;
    cows        = '0;
    entry_valid = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      for (int j = 0; j < int'(NUM_DIGITS); j++) begin
        if (guess[i] == secret[j]) begin
          if (i == j) bulls = bulls + COUNT_W'(1);
          else        cows  = cows + COUNT_W'(1);
        end
        if ((j > i) && (guess[i] == guess[j])) entry_valid = 1'b0;
      end
`ifdef DECIMAL_DIGITS_EN
      if (guess[i] > DIGIT_W'(9)) entry_valid = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/bulls_cows_game_ctrl.sv
// Two-player Bulls and Cows controller: secret capture, alternating turns, scoring, match points.
// DECIMAL_DIGITS_EN (scorer) limits accepted digits to 0..9.
module bulls_cows_game_ctrl
  import bulls_cows_pkg::*;
#(
  parameter int unsigned RESULT_HOLD = 200_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  bulls_cows_game_ctrl_if.slave bus
);

  localparam int unsigned HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  ctrl_state_t         state;
  game_state_t         game_state_q;
  logic                confirm_q;
  code_t               sw_q;
  code_t               secret1;
  code_t               secret2;
  code_t               guess_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                guess_confirmed_q;
  logic [COUNT_W-1:0]  bull_q;
  logic [COUNT_W-1:0]  cow_q;
  logic [POINTS_W-1:0] j1_points_q;
  logic [POINTS_W-1:0] j2_points_q;
  logic                invalid_q;

  code_t               score_guess;
  code_t               score_secret;
  logic [COUNT_W-1:0]  bulls;
  logic [COUNT_W-1:0]  cows;
  logic                entry_valid;
  logic                is_win;

  // Scorer checks raw switches for validity, and the latched guess during scoring.
  always_comb begin
    score_guess  = ((state == S_J1_SCORE) || (state == S_J2_SCORE)) ? guess_q : sw_q;
    score_secret = ((state == S_J1_GUESS) || (state == S_J1_SCORE)) ? secret2 : secret1;
  end

  assign is_win = (bulls == COUNT_W'(WIN_BULLS));

  bulls_cows_scorer u_scorer (
    .guess       (score_guess),
    .secret      (score_secret),
    .bulls       (bulls),
    .cows        (cows),
    .entry_valid (entry_valid)
  );

  // Confirm and SW are registered together so the FSM sees a coherent entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= S_J1_SETUP;
      game_state_q      <= J1_SETUP;
      confirm_q         <= 1'b0;
      sw_q              <= '0;
      secret1           <= '0;
      secret2           <= '0;
      guess_q           <= '0;
      hold_cnt          <= '0;
      guess_confirmed_q <= 1'b0;
      bull_q            <= '0;
      cow_q             <= '0;
      j1_points_q       <= '0;
      j2_points_q       <= '0;
      invalid_q         <= 1'b0;
    end else begin
      confirm_q <= bus.confirm;
      sw_q      <= code_t'(bus.SW);
      invalid_q <= 1'b0;
      case (state)
        S_J1_SETUP: if (confirm_q) begin
          if (entry_valid) begin
            secret1      <= sw_q;
            state        <= S_J2_SETUP;
            game_state_q <= J2_SETUP;
          end else begin
            invalid_q <= 1'b1;
          end
        end
        S_J2_SETUP: if (confirm_q) begin
          if (entry_valid) begin
            secret2      <= sw_q;
            state        <= S_J1_GUESS;
            game_state_q <= J1_GUESS;
          end else begin
            invalid_q <= 1'b1;
          end
        end
        S_J1_GUESS: if (confirm_q) begin
          if (entry_valid) begin
            guess_q <= sw_q;
            state   <= S_J1_SCORE;
          end else begin
            invalid_q <= 1'b1;
          end
        end
        S_J2_GUESS: if (confirm_q) begin
          if (entry_valid) begin
            guess_q <= sw_q;
            state   <= S_J2_SCORE;
          end else begin
            invalid_q <= 1'b1;
          end
        end
        S_J1_SCORE, S_J2_SCORE: begin
          bull_q <= bulls;
          if (is_win) begin
            cow_q        <= '0;
            state        <= S_END;
            game_state_q <= END_GAME;
            if (state == S_J1_SCORE) begin
              if (j1_points_q != POINTS_W'(POINTS_MAX)) j1_points_q <= j1_points_q + POINTS_W'(1);
            end else begin
              if (j2_points_q != POINTS_W'(POINTS_MAX)) j2_points_q <= j2_points_q + POINTS_W'(1);
            end
          end else begin
            cow_q             <= cows;
            guess_confirmed_q <= 1'b1;
            hold_cnt          <= HOLD_W'(RESULT_HOLD - 1);
            state             <= (state == S_J1_SCORE) ? S_J1_SHOW : S_J2_SHOW;
          end
        end
        // Result stays on display; confirms are ignored until the hold expires.
        S_J1_SHOW, S_J2_SHOW: begin
          if (hold_cnt == '0) begin
            guess_confirmed_q <= 1'b0;
            bull_q            <= '0;
            cow_q             <= '0;
            if (state == S_J1_SHOW) begin
              state        <= S_J2_GUESS;
              game_state_q <= J2_GUESS;
            end else begin
              state        <= S_J1_GUESS;
              game_state_q <= J1_GUESS;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        S_END: if (confirm_q) begin
          secret1      <= '0;
          secret2      <= '0;
          guess_q      <= '0;
          bull_q       <= '0;
          cow_q        <= '0;
          state        <= S_J1_SETUP;
          game_state_q <= J1_SETUP;
        end
        default: begin
          state        <= S_J1_SETUP;
          game_state_q <= J1_SETUP;
        end
      endcase
    end
  end

  assign bus.game_state      = game_state_q;
  assign bus.guess_confirmed = guess_confirmed_q;
  assign bus.bull_count      = bull_q;
  assign bus.cow_count       = cow_q;
  assign bus.J1_points       = j1_points_q;
  assign bus.J2_points       = j2_points_q;
  assign bus.invalid_entry   = invalid_q;

endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// Directed bench for bulls_cows_game_ctrl with a short result hold.
module tb_bulls_cows_game_ctrl;
  import bulls_cows_pkg::*;

  localparam int unsigned HOLD = 4;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  bulls_cows_game_ctrl_if bus ();

  bulls_cows_game_ctrl #(.RESULT_HOLD(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge N.
  task automatic press(input logic [15:0] code);
    bus.SW      = code;
    bus.confirm = 1'b1;
    @(negedge clock);
    bus.confirm = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] gs, input logic gc,
                               input logic [2:0] b, input logic [2:0] c);
    check_val({tag, "_state"}, 32'(bus.game_state), 32'(gs));
    check_val({tag, "_gc"},    32'(bus.guess_confirmed), 32'(gc));
    check_val({tag, "_bull"},  32'(bus.bull_count), 32'(b));
    check_val({tag, "_cow"},   32'(bus.cow_count), 32'(c));
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.confirm = 1'b0;
    bus.SW      = 16'h0000;
    repeat (2) @(negedge clock);
    check_outputs("rst", 3'b000, 1'b0, 3'd0, 3'd0);
    check_val("rst_p1", 32'(bus.J1_points), 32'd0);
    check_val("rst_p2", 32'(bus.J2_points), 32'd0);
    check_val("rst_inv", 32'(bus.invalid_entry), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Repeated digit rejected in setup
    press(16'h1123);
    @(negedge clock);
    check_val("dup_inv_pulse", 32'(bus.invalid_entry), 32'd1);
    check_val("dup_state", 32'(bus.game_state), 32'h0);
    @(negedge clock);
    check_val("dup_inv_clear", 32'(bus.invalid_entry), 32'd0);

    press(16'h1234);
    @(negedge clock);
    check_val("s1_state", 32'(bus.game_state), 32'h1);
    press(16'h5678);
    @(negedge clock);
    check_val("s2_state", 32'(bus.game_state), 32'h2);

    // J1 guess 5687 vs 5678: 2 bulls, 2 cows
    press(16'h5687);
    @(negedge clock);
    check_outputs("g1_n1", 3'b010, 1'b0, 3'd0, 3'd0);
    @(negedge clock);
    check_outputs("g1_n2", 3'b010, 1'b1, 3'd2, 3'd2);
    // Confirms during the hold are ignored; hold lasts exactly HOLD cycles
    for (int k = 0; k < int'(HOLD) - 1; k++) begin
      bus.SW      = 16'h9abc;
      bus.confirm = 1'b1;
      @(negedge clock);
      check_outputs("hold", 3'b010, 1'b1, 3'd2, 3'd2);
    end
    bus.confirm = 1'b0;
    @(negedge clock);
    check_outputs("hold_end", 3'b011, 1'b0, 3'd0, 3'd0);
    @(negedge clock);
    check_outputs("j2_turn", 3'b011, 1'b0, 3'd0, 3'd0);

    // J2 cracks secret1
    press(16'h1234);
    @(negedge clock);
    @(negedge clock);
    check_outputs("j2_win", 3'b111, 1'b0, 3'd4, 3'd0);
    check_val("j2_win_pts", 32'(bus.J2_points), 32'd1);
    check_val("j2_win_p1", 32'(bus.J1_points), 32'd0);
    press(16'h0000);
    @(negedge clock);
    check_outputs("restart", 3'b000, 1'b0, 3'd0, 3'd0);
    check_val("restart_p2", 32'(bus.J2_points), 32'd1);

    // J1 wins repeatedly; points saturate at 255
    for (int w = 0; w < 256; w++) begin
      press(16'h1234);
      @(negedge clock);
      press(16'h5678);
      @(negedge clock);
      press(16'h5678);
      @(negedge clock);
      @(negedge clock);
      if (w == 254) check_val("p1_reach_max", 32'(bus.J1_points), 32'd255);
      press(16'h0000);
      @(negedge clock);
    end
    check_val("p1_saturate", 32'(bus.J1_points), 32'd255);
    check_val("p1_sat_p2", 32'(bus.J2_points), 32'd1);

    // J1 miss with all cows, then J2 miss; reset during J2 show
    press(16'h1234);
    @(negedge clock);
    press(16'h5678);
    @(negedge clock);
    press(16'h8765);
    @(negedge clock);
    @(negedge clock);
    check_outputs("g1_cows", 3'b010, 1'b1, 3'd0, 3'd4);
    repeat (HOLD) @(negedge clock);
    check_val("g1_cows_done", 32'(bus.game_state), 32'h3);
    press(16'h1243);
    @(negedge clock);
    @(negedge clock);
    check_outputs("g2_show", 3'b011, 1'b1, 3'd2, 3'd2);
    #2 reset = 1'b1;
    #1;
    check_outputs("async_rst", 3'b000, 1'b0, 3'd0, 3'd0);
    check_val("async_rst_p1", 32'(bus.J1_points), 32'd0);
    check_val("async_rst_p2", 32'(bus.J2_points), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Hex digit entry: rejected only when decimal digits are enforced
    press(16'h12a4);
    @(negedge clock);
`ifdef DECIMAL_DIGITS_EN
    check_val("hex_inv", 32'(bus.invalid_entry), 32'd1);
    check_val("hex_state", 32'(bus.game_state), 32'h0);
`else
    check_val("hex_inv", 32'(bus.invalid_entry), 32'd0);
    check_val("hex_state", 32'(bus.game_state), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bulls_cows_game_ctrl.md
Name: bulls_cows_game_ctrl

Overview:
Game controller for two-player Bulls and Cows. It captures each player's secret code, alternates guess turns, scores each guess, and keeps the match score. It sits directly upstream of the seven-segment/LED display stage and drives that stage's game_state, guess_confirmed, bull_count, cow_count, J1_points and J2_points inputs. Codes come from SW[15:0] as four 4-bit digits; confirm is a debounced single-cycle pulse.

Parameters:
RESULT_HOLD, 200_000_000, number of clock cycles the guess result stays on the display (2 s at 100 MHz); must be at least 1.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
confirm  in  1  single-cycle pulse that commits SW as a secret or guess
SW  in  16  code digits: d3=SW[15:12] (leftmost) .. d0=SW[3:0]
game_state  out  3  000 J1_SETUP, 001 J2_SETUP, 010 J1_GUESS, 011 J2_GUESS, 111 END_GAME
guess_confirmed  out  1  high while a non-winning guess result is shown
bull_count  out  3  digits matching in value and position (0..4)
cow_count  out  3  digits present in the secret at a different position (0..4)
J1_points  out  8  match wins of player 1, saturating
J2_points  out  8  match wins of player 2, saturating
invalid_entry  out  1  one-cycle pulse when a confirm is rejected

Behaviour:
- Reset (asynchronous) forces: FSM to S_J1_SETUP, game_state=000, guess_confirmed=0, bull/cow_count=0, points=0, invalid_entry=0, both secrets=0, hold counter=0. All outputs are registered.
- Validity: an entry is valid only when all four digits are pairwise distinct. A confirm with an invalid entry pulses invalid_entry for 1 cycle and leaves the state unchanged.
- Internal states and the game_state they drive:
  - S_J1_SETUP (000): a valid confirm latches secret1 and moves to S_J2_SETUP.
  - S_J2_SETUP (001): a valid confirm latches secret2 and moves to S_J1_GUESS.
  - S_J1_GUESS (010): a valid confirm latches the guess (compared against secret2) and moves to S_J1_SCORE.
  - S_J1_SCORE (010): lasts 1 cycle and registers the bull/cow counts.
    - bulls==4: go to S_END, J1_points+1.
    - otherwise: go to S_J1_SHOW with guess_confirmed=1 and the hold counter loaded to RESULT_HOLD-1.
  - S_J1_SHOW (010): counts down while confirm is ignored. When the counter reaches 0, go to S_J2_GUESS, clear guess_confirmed and clear bull/cow_count to 0.
  - S_J2_GUESS, S_J2_SCORE, S_J2_SHOW (011): mirror the J1 states, compare against secret1, credit J2_points on a win, then return to S_J1_GUESS.
  - S_END (111): bull_count holds 4, cow_count=0, guess_confirmed=0. A confirm (SW not checked) clears the secrets and counts and goes to S_J1_SETUP. Points are kept.
- Latency: for a confirm sampled at edge N, counts are visible after edge N+2, and guess_confirmed (or game_state=111) rises after edge N+2.
- Scoring: bulls = count of i with g[i]==s[i]. cows = count of i≠j with g[i]==s[j]. Because both codes have distinct digits, bulls+cows ≤ 4.
- Points saturate at 255 and never wrap.
- confirm while in a SCORE state is ignored.
- Reset asserted mid-game aborts immediately to the reset values, points included.

Optional Feature:
DECIMAL_DIGITS_EN:
- Defined: validity additionally requires every digit ≤ 9. Any digit A..F rejects the entry with an invalid_entry pulse.
- Undefined: any distinct hex digits are accepted.

Decomposition:
- Package bulls_cows_pkg holds:
  - game_state_t enum with the five encodings above (shared with the display stage).
  - digit_t (logic [3:0]) and code_t (digit_t [3:0]).
  - WIN_BULLS=4 and POINTS_MAX=255.
- Sub-module bulls_cows_scorer: combinational; takes guess and secret code_t and returns bulls, cows and entry_valid (it contains the distinctness and optional decimal check). The controller registers its outputs.

Test Plan:
1. Reset, then secret1=0x1234, secret2=0x5678, J1 guesses 0x5687 -> after 2 cycles game_state=010, guess_confirmed=1, bull=2, cow=2. After RESULT_HOLD=4 cycles: game_state=011, counts=0.
2. SW=0x1123 confirmed in J1_SETUP -> invalid_entry pulses once, game_state stays 000.
3. J2 guesses 0x1234 against secret1=0x1234 -> game_state=111, bull_count=4, J2_points=1. Confirm -> game_state=000, J2_points still 1.
4. confirm pulses during S_J1_SHOW -> ignored; the hold lasts exactly RESULT_HOLD cycles.
5. Force J1_points=255, J1 wins -> stays 255.
6. Reset asserted during S_J2_SHOW -> all outputs return to reset values asynchronously. With DECIMAL_DIGITS_EN defined, SW=0x12A4 in setup is rejected.
